display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed scan controller for a four-digit display. It drives the select inputs (I1, I0) and the active-low enable (EN) of the 2-to-4 active-low decoder stage directly downstream. It presents the matching 4-bit digit nibble for the segment path. A blanking interval precedes every digit, and the displayed value is double-buffered so that updates take effect only at frame boundaries.

## Interface
- DWELL, 50000: cycles each digit is enabled; legal range ≥1.
- BLANK, 8: cycles EN is held high before each digit; legal range ≥1.
- CW, 16: internal cycle-counter width; must hold max(DWELL, BLANK)−1.
- CLK  in  1  single system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- RUN  in  1  level; 1 = scan, 0 = stop and blank.
- LOAD  in  1  one-cycle strobe that captures VALUE.
- VALUE  in  16  four nibbles; digit k = VALUE[4k+3:4k].
- I0  out  1  decoder select LSB.
- I1  out  1  decoder select MSB.
- EN  out  1  decoder enable, active-low (1 = all decoder outputs inactive).
- NIBBLE  out  4  nibble of the currently enabled digit.
- FRAME_DONE  out  1  one-cycle pulse when digit 3 completes.
- ACTIVE  out  1  1 whenever the state is not IDLE.

## Operation
- All outputs are registered.
- Reset values (asynchronous, RST_N=0): state=IDLE, EN=1, I1=I0=0, NIBBLE=0, FRAME_DONE=0, ACTIVE=0, SHADOW=0, PENDING=0, pend=0, idx=0, cnt=0.
- Storage:
  - SHADOW is the displayed value.
  - PENDING plus the flag pend hold the next value.
- State machine:
  - IDLE:
    - EN=1, idx=0, cnt=0, NIBBLE=0.
    - RUN=1 → BLANK with cnt=0.
  - BLANK:
    - EN=1; cnt counts up.
    - At cnt=BLANK−1 → SHOW, cnt=0, EN←0, NIBBLE←SHADOW[4·idx+3:4·idx].
  - SHOW:
    - EN=0; {I1,I0}=idx; cnt counts up.
    - At cnt=DWELL−1 → BLANK, cnt=0, EN←1, idx←idx+1 mod 4 (3 wraps to 0).
    - If idx was 3, FRAME_DONE←1 for one cycle and the frame boundary occurs.
- RUN=0 sampled in any state → IDLE on that edge:
  - EN←1, idx←0, cnt←0, NIBBLE←0.
  - No FRAME_DONE; the partial frame is discarded.
- {I1,I0} change only on the edge where EN goes 1. They are never changed while EN=0, so the decoder never glitches while enabled.
- LOAD handling:
  - In IDLE: SHADOW←VALUE directly.
  - Otherwise: PENDING←VALUE, pend←1. A later LOAD before the boundary overwrites PENDING (last wins).
- Frame boundary: if pend, SHADOW←PENDING and pend←0.
- LOAD on the boundary edge: SHADOW←VALUE (the new VALUE wins) and pend←0.
- Entering IDLE with pend=1: SHADOW←PENDING, pend←0.

## Timing
- Let t0 be the edge where RUN=1 is sampled in IDLE:
  - BLANK is entered at t0.
  - EN falls at t0+BLANK.
  - EN rises at t0+BLANK+DWELL.
- Digit period is BLANK+DWELL cycles; frame period is 4·(BLANK+DWELL).
- FRAME_DONE is high for exactly the cycle after edge t0+4·(BLANK+DWELL), coincident with EN rising after digit 3.
- RUN fall: EN=1 one edge after RUN=0 is sampled.
- LOAD-to-display latency:
  - In IDLE: the next SHOW entry.
  - Otherwise: the first digit-0 SHOW after the next frame boundary.
- ACTIVE=1 from edge t0 until the edge entering IDLE.
- Reset deassertion mid-operation restarts from IDLE; no state survives reset.

## Test plan
All scenarios use DWELL=4 and BLANK=2.
- Reset during SHOW of digit 2: RST_N=0 → EN=1, I1=I0=0, NIBBLE=0, FRAME_DONE=0, ACTIVE=0 immediately, without waiting for a CLK edge.
- Basic scan:
  - Stimulus: LOAD with VALUE=16'hA5C3 in IDLE, then RUN=1 sampled at t0.
  - EN low over [t0+2, t0+6) with {I1,I0}=00 and NIBBLE=3.
  - Subsequent digits show {01,C}, {10,5}, {11,A}.
  - FRAME_DONE pulses once after t0+24.
- Mid-frame update:
  - Stimulus: LOAD with VALUE=16'h1234 while digit 1 is enabled, with prior value 16'hA5C3.
  - Digits 2 and 3 still show 5 and A.
  - The next frame shows 4, 3, 2, 1.
- LOAD on the boundary:
  - Stimulus: PENDING=16'h1111, then LOAD 16'h2222 on the FRAME_DONE edge.
  - The next frame shows 2, 2, 2, 2; 16'h1111 is never displayed.
- Stop and restart:
  - Stimulus: RUN=0 during SHOW of digit 2.
  - EN=1 and {I1,I0}=00 at the next edge; no FRAME_DONE.
  - After RUN=1, digit 0 is enabled 2 cycles later.
- Select stability: run 3 frames → {I1,I0} never changes while EN=0; the 3→0 wrap is observed; exactly 3 FRAME_DONE pulses, 24 cycles apart.

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// Run/load controls in, decoder select/enable and digit nibble out.
interface display_scan_ctrl_if;
   logic        run;
   logic        load;
   logic [15:0] value;
   logic        i0;
   logic        i1;
   logic        en;
   logic [3:0]  nibble;
   logic        frame_done;
   logic        active;

   modport master (
      output run, load, value,
      input  i0, i1, en, nibble, frame_done, active
   );

   modport slave (
      input  run, load, value,
      output i0, i1, en, nibble, frame_done, active
   );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit time-multiplexed scan controller with blanking and
// frame-boundary double buffering of the displayed value.
module display_scan_ctrl #(
   parameter int DWELL = 50000,
   parameter int BLANK = 8,
   parameter int CW    = 16
) (
   input logic               clk,
   input logic               rst_n,
   display_scan_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BLANK,
      S_SHOW
   } state_t;

   localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] BL_LAST = CW'(BLANK - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic          en_q, en_d;
   logic [3:0]    nib_q, nib_d;
   logic          fd_q, fd_d;
   logic          act_q, act_d;
   logic [15:0]   shadow_q, shadow_d;
   logic [15:0]   pending_q, pending_d;
   logic          pend_q, pend_d;
   logic          boundary;
   logic          to_idle;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      en_d      = en_q;
      nib_d     = nib_q;
      fd_d      = 1'b0;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      pend_d    = pend_q;
      boundary  = 1'b0;
      to_idle   = 1'b0;

      if (!bus.run) begin
         to_idle = (state_q != S_IDLE);
         state_d = S_IDLE;
         cnt_d   = '0;
         idx_d   = 2'd0;
         en_d    = 1'b1;
         nib_d   = 4'h0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_BLANK;
               cnt_d   = '0;
            end
            S_BLANK: begin
               if (cnt_q == BL_LAST) begin
                  state_d = S_SHOW;
                  cnt_d   = '0;
                  en_d    = 1'b0;
                  nib_d   = shadow_q[{idx_q, 2'b00} +: 4];
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_SHOW: begin
               // select lines move only here, as the decoder is disabled
               if (cnt_q == DW_LAST) begin
                  state_d  = S_BLANK;
                  cnt_d    = '0;
                  en_d     = 1'b1;
                  idx_d    = idx_q + 2'd1;
                  fd_d     = (idx_q == 2'd3);
                  boundary = (idx_q == 2'd3);
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (boundary || to_idle) begin
         if (pend_q) shadow_d = pending_q;
         pend_d = 1'b0;
      end

      // a load landing on a swap edge beats the older pending value
      if (bus.load) begin
         if (state_q == S_IDLE || boundary || to_idle) begin
            shadow_d = bus.value;
            pend_d   = 1'b0;
         end else begin
            pending_d = bus.value;
            pend_d    = 1'b1;
         end
      end

      act_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= 2'd0;
         en_q      <= 1'b1;
         nib_q     <= 4'h0;
         fd_q      <= 1'b0;
         act_q     <= 1'b0;
         shadow_q  <= 16'h0;
         pending_q <= 16'h0;
         pend_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         en_q      <= en_d;
         nib_q     <= nib_d;
         fd_q      <= fd_d;
         act_q     <= act_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         pend_q    <= pend_d;
      end
   end

   assign bus.en         = en_q;
   assign bus.i1         = idx_q[1];
   assign bus.i0         = idx_q[0];
   assign bus.nibble     = nib_q;
   assign bus.frame_done = fd_q;
   assign bus.active     = act_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus random run/load
// traffic against a frame-time arithmetic model.
module tb_display_scan_ctrl;

   localparam int DW = 4;
   localparam int BL = 2;
   localparam int P  = BL + DW;
   localparam int FR = 4 * P;

   logic clk = 1'b0;
   logic rst_n;

   display_scan_ctrl_if bus ();

   display_scan_ctrl #(
      .DWELL(DW),
      .BLANK(BL),
      .CW   (16)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total    = 0;

   // model: running flag, edges since start, displayed/pending values
   bit          m_run;
   int          m_t;
   logic [15:0] m_shadow;
   logic [15:0] m_pendv;
   bit          m_pend;
   logic [3:0]  m_nib;

   task automatic model_reset();
      m_run    = 0;
      m_t      = 0;
      m_shadow = 16'h0;
      m_pendv  = 16'h0;
      m_pend   = 0;
      m_nib    = 4'h0;
   endtask

   task automatic model_step();
      int pos;
      if (!bus.run) begin
         if (m_run && m_pend) m_shadow = m_pendv;
         if (m_run) m_pend = 0;
         if (bus.load) begin
            m_shadow = bus.value;
            m_pend   = 0;
         end
         m_run = 0;
         m_t   = 0;
         m_nib = 4'h0;
      end else if (!m_run) begin
         if (bus.load) m_shadow = bus.value;
         m_run = 1;
         m_t   = 0;
      end else begin
         m_t = m_t + 1;
         pos = m_t % FR;
         if (pos % P == BL) m_nib = m_shadow[4*(pos/P) +: 4];
         if (pos == 0) begin
            if (m_pend) m_shadow = m_pendv;
            m_pend = 0;
         end
         if (bus.load) begin
            if (pos == 0) begin
               m_shadow = bus.value;
               m_pend   = 0;
            end else begin
               m_pendv = bus.value;
               m_pend  = 1;
            end
         end
      end
   endtask

   // {en, i1, i0, nibble, frame_done, active}
   function automatic logic [8:0] exp_vec();
      int pos;
      logic e_en;
      logic e_fd;
      if (!m_run) return 9'h100;
      pos  = m_t % FR;
      e_en = ((pos % P) < BL);
      e_fd = (m_t > 0 && pos == 0);
      return {e_en, 2'(pos / P), m_nib, e_fd, 1'b1};
   endfunction

   function automatic logic [8:0] obs();
      return {bus.en, bus.i1, bus.i0, bus.nibble,
              bus.frame_done, bus.active};
   endfunction

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic advance_to(input int target);
      int k = 0;
      while (!(m_run && (m_t % FR) == target) && k < 100) begin
         step();
         k++;
      end
      if (k >= 100) begin
         total++;
         $display("FAIL advance pos %0d not reached", target);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b1;
      bus.run   = 1'b0;
      bus.load  = 1'b0;
      bus.value = 16'h0;
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (obs() !== 9'h100)
         $display("FAIL reset_init got %b want %b", obs(), 9'h100);
      else pass_cnt++;
      rst_n = 1'b1;
      model_reset();
      bus.load  = 1'b1;
      bus.value = 16'h9876;
      step();
      bus.load = 1'b0;
      bus.run  = 1'b1;
      step();
      for (int k = 0; k < 15; k++) begin
         step();
         total++;
         if (obs() !== exp_vec())
            $display("FAIL reset_pre t=%0d got %b want %b",
                     m_t, obs(), exp_vec());
         else pass_cnt++;
      end
      total++;
      if ({bus.en, bus.i1, bus.i0} !== 3'b010)
         $display("FAIL reset_pre_show got %b want 010",
                  {bus.en, bus.i1, bus.i0});
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (obs() !== 9'h100)
         $display("FAIL reset_async got %b want %b", obs(), 9'h100);
      else pass_cnt++;
      model_reset();
      bus.run = 1'b0;
      @(negedge clk);
      total++;
      if (obs() !== 9'h100)
         $display("FAIL reset_hold got %b want %b", obs(), 9'h100);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic_scan();
      logic [3:0] digs [4];
      int fd_n = 0;
      int fd_t = -1;
      digs = '{4'h3, 4'hC, 4'h5, 4'hA};
      bus.load  = 1'b1;
      bus.value = 16'hA5C3;
      step();
      bus.load = 1'b0;
      bus.run  = 1'b1;
      step();
      for (int k = 1; k < 30; k++) begin
         step();
         total++;
         if (obs() !== exp_vec())
            $display("FAIL basic t=%0d got %b want %b",
                     m_t, obs(), exp_vec());
         else pass_cnt++;
         if (bus.frame_done) begin
            fd_n++;
            fd_t = k;
         end
         if (k < FR && (k % P) >= BL) begin
            total++;
            if ({bus.en, bus.i1, bus.i0, bus.nibble} !==
                {1'b0, 2'(k / P), digs[k/P]})
               $display("FAIL basic_digit t=%0d got %b want %b", k,
                        {bus.en, bus.i1, bus.i0, bus.nibble},
                        {1'b0, 2'(k / P), digs[k/P]});
            else pass_cnt++;
         end
      end
      total++;
      if (fd_n != 1 || fd_t != FR)
         $display("FAIL basic_fd got n=%0d t=%0d want n=1 t=%0d",
                  fd_n, fd_t, FR);
      else pass_cnt++;
   endtask

   task automatic test_mid_frame_update();
      logic [3:0] want [6];
      logic [3:0] shown [$];
      logic prev_en;
      want = '{4'h5, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
      advance_to(P + BL);
      bus.load  = 1'b1;
      bus.value = 16'h1234;
      step();
      bus.load = 1'b0;
      prev_en  = bus.en;
      for (int k = 0; k < 36; k++) begin
         step();
         total++;
         if (obs() !== exp_vec())
            $display("FAIL mid t=%0d got %b want %b",
                     m_t, obs(), exp_vec());
         else pass_cnt++;
         if (prev_en && !bus.en) shown.push_back(bus.nibble);
         prev_en = bus.en;
      end
      total++;
      if (shown.size() != 6)
         $display("FAIL mid_count got %0d want 6", shown.size());
      else begin
         pass_cnt++;
         for (int i = 0; i < 6; i++) begin
            total++;
            if (shown[i] !== want[i])
               $display("FAIL mid_digit%0d got %h want %h",
                        i, shown[i], want[i]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_load_boundary();
      logic [3:0] shown [$];
      logic prev_en;
      advance_to(FR - 3);
      bus.load  = 1'b1;
      bus.value = 16'h1111;
      step();
      bus.load = 1'b0;
      step();
      bus.load  = 1'b1;
      bus.value = 16'h2222;
      step();
      bus.load = 1'b0;
      total++;
      if (bus.frame_done !== 1'b1)
         $display("FAIL bnd_fd got %b want 1", bus.frame_done);
      else pass_cnt++;
      prev_en = bus.en;
      for (int k = 0; k < 2 * FR; k++) begin
         step();
         total++;
         if (obs() !== exp_vec())
            $display("FAIL bnd t=%0d got %b want %b",
                     m_t, obs(), exp_vec());
         else pass_cnt++;
         if (prev_en && !bus.en) shown.push_back(bus.nibble);
         prev_en = bus.en;
      end
      total++;
      if (shown.size() != 8)
         $display("FAIL bnd_count got %0d want 8", shown.size());
      else pass_cnt++;
      foreach (shown[i]) begin
         total++;
         if (shown[i] !== 4'h2)
            $display("FAIL bnd_digit%0d got %h want 2", i, shown[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_stop_restart();
      int fd_n = 0;
      advance_to(P + BL);
      bus.load  = 1'b1;
      bus.value = 16'h3333;
      step();
      bus.load = 1'b0;
      advance_to(2 * P + BL + 1);
      bus.run = 1'b0;
      step();
      total++;
      if (obs() !== 9'h100)
         $display("FAIL stop got %b want %b", obs(), 9'h100);
      else pass_cnt++;
      for (int k = 0; k < 5; k++) begin
         step();
         if (bus.frame_done) fd_n++;
      end
      total++;
      if (fd_n != 0)
         $display("FAIL stop_fd got %0d want 0", fd_n);
      else pass_cnt++;
      bus.run = 1'b1;
      step();
      step();
      total++;
      if ({bus.en, bus.active} !== 2'b11)
         $display("FAIL restart_blank got %b want 11",
                  {bus.en, bus.active});
      else pass_cnt++;
      step();
      total++;
      if ({bus.en, bus.i1, bus.i0, bus.nibble} !== 7'b0_00_0011)
         $display("FAIL restart_digit got %b want 0000011",
                  {bus.en, bus.i1, bus.i0, bus.nibble});
      else pass_cnt++;
   endtask

   task automatic test_select_stability();
      int fd_t [$];
      int viol  = 0;
      int wraps = 0;
      logic [8:0] prev;
      logic [8:0] cur;
      bus.run = 1'b0;
      step();
      bus.run = 1'b1;
      step();
      prev = obs();
      for (int k = 1; k <= 3 * FR + 2; k++) begin
         step();
         cur = obs();
         total++;
         if (cur !== exp_vec())
            $display("FAIL sel t=%0d got %b want %b", m_t, cur, exp_vec());
         else pass_cnt++;
         if (cur[7:6] != prev[7:6]) begin
            if (!(prev[8] == 1'b0 && cur[8] == 1'b1)) viol++;
            if (prev[7:6] == 2'd3 && cur[7:6] == 2'd0) wraps++;
         end
         if (cur[1]) fd_t.push_back(k);
         prev = cur;
      end
      total++;
      if (viol != 0) $display("FAIL sel_glitch got %0d want 0", viol);
      else pass_cnt++;
      total++;
      if (wraps != 3) $display("FAIL sel_wrap got %0d want 3", wraps);
      else pass_cnt++;
      total++;
      if (fd_t.size() != 3)
         $display("FAIL sel_fd_count got %0d want 3", fd_t.size());
      else begin
         pass_cnt++;
         total++;
         if (fd_t[1] - fd_t[0] != FR || fd_t[2] - fd_t[1] != FR)
            $display("FAIL sel_fd_gap got %0d,%0d want %0d",
                     fd_t[1] - fd_t[0], fd_t[2] - fd_t[1], FR);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 800; k++) begin
         bus.run = ($urandom_range(0, 39) != 0);
         if (bus.run || !m_run)
            bus.load = ($urandom_range(0, 7) == 0);
         else
            bus.load = 1'b0;
         bus.value = 16'($urandom);
         step();
         total++;
         if (obs() !== exp_vec())
            $display("FAIL random k=%0d got %b want %b",
                     k, obs(), exp_vec());
         else pass_cnt++;
      end
      bus.load = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_scan();
      test_mid_frame_update();
      test_load_boundary();
      test_stop_restart();
      test_select_stability();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
